la_capture_core: RTL and testbench

Parametrised embedded logic-analyser capture core, the successor to the fixed-width single-trigger analyser core. Samples a DATA_W-bit probe bus every clk_i cycle into a circular buffer. Supports mask/value triggering with level, edge and immediate modes, and a programmable pre-trigger depth. After capture, the buffer is read back in trigger-relative order by the JTAG/control front end.

---
 rtl/la_capture_core.sv | 226 ++++++++++++++++++++++
 tb/tb_la_capture_core.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_core.sv
// ---------------------------------------------------------------------------
// la_capture_core
// Embedded logic-analyser capture core. Samples a DATA_W-bit probe bus into
// a circular buffer every clock, triggers on a mask/value compare (level,
// rising, falling or immediate) and keeps a programmable number of
// pre-trigger samples. After capture the buffer is read back in
// trigger-relative order (logical index 0 = oldest sample).
//
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   data_i                 probe bus, sampled every cycle
//   trig_mask_i/value_i    trigger compare mask and value (latched on arm)
//   trig_mode_i            0 level, 1 rising, 2 falling, 3 immediate
//   pretrig_i              requested pre-trigger depth (latched on arm)
//   arm_i, abort_i         single-cycle control pulses (abort wins)
//   rd_en_i, rd_addr_i     readout request, logical sample index
//   rd_data_o, rd_valid_o  readout data, valid one cycle after rd_en_i
//   state_o                0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE
//   triggered_o, done_o    capture status
//   start_addr_o           physical address of logical sample 0
// ---------------------------------------------------------------------------
module la_capture_core #(
  parameter  int unsigned DATA_W = 38,
  parameter  int unsigned DEPTH  = 1024,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [2:0]        state_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] start_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0]        M_LEVEL = 2'd0;
  localparam logic [1:0]        M_RISE  = 2'd1;
  localparam logic [1:0]        M_FALL  = 2'd2;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_post_cnt;
  logic [ADDR_W-1:0]   r_pre_n;
  logic [ADDR_W-1:0]   r_start_addr;
  logic [DATA_W-1:0]   r_mask;
  logic [DATA_W-1:0]   r_value;
  logic [1:0]          r_mode;
  logic                r_match_d;
  logic                r_triggered;
  logic                r_done;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;

  logic [DATA_W-1:0]   w_mask;
  logic [DATA_W-1:0]   w_value;
  logic                w_match;
  logic                w_trig;
  logic                w_wr_en;
  logic                w_cnt_inc;
  logic                w_trig_load;
  logic                w_post_dec;
  logic                w_done_set;
  logic                w_rd_fire;
  logic [ADDR_W-1:0]   w_rd_idx;

  // On the arm cycle the compare uses the incoming config so that match_d
  // is already coherent with the new capture's mask/value.
  always_comb begin : match_logic
    w_mask  = arm_i ? trig_mask_i  : r_mask;
    w_value = arm_i ? trig_value_i : r_value;
    w_match = ((data_i ^ w_value) & w_mask) == '0;
    w_trig  = 1'b1;
    case (r_mode)
      M_LEVEL: w_trig = w_match;
      M_RISE:  w_trig = w_match & ~r_match_d;
      M_FALL:  w_trig = ~w_match & r_match_d;
      default: w_trig = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin : state_reg
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic; abort has priority over arm
  always_comb begin : next_state
    w_state_nxt = r_state;
    if (abort_i) begin
      w_state_nxt = S_IDLE;
    end else if (arm_i) begin
      w_state_nxt = (pretrig_i != '0) ? S_PRE : S_WAIT;
    end else begin
      case (r_state)
        S_PRE:   if ((r_cnt + ONE) == r_pre_n) w_state_nxt = S_WAIT;
        S_WAIT:  if (w_trig) w_state_nxt = (r_pre_n == LAST) ? S_DONE : S_POST;
        S_POST:  if (r_post_cnt == ONE) w_state_nxt = S_DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Per-state datapath controls; an arm or abort cycle performs no write
  always_comb begin : output_decode
    w_wr_en     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_trig_load = 1'b0;
    w_post_dec  = 1'b0;
    w_done_set  = 1'b0;
    w_rd_fire   = (r_state == S_DONE) && rd_en_i;
    if (!abort_i && !arm_i) begin
      case (r_state)
        S_PRE: begin
          w_wr_en   = 1'b1;
          w_cnt_inc = 1'b1;
        end
        S_WAIT: begin
          w_wr_en     = 1'b1;
          w_trig_load = w_trig;
          w_done_set  = w_trig && (r_pre_n == LAST);
        end
        S_POST: begin
          w_wr_en    = 1'b1;
          w_post_dec = 1'b1;
          w_done_set = (r_post_cnt == ONE);
        end
        default: ;
      endcase
    end
  end

  // Capture pointers, counters and status
  always_ff @(posedge clk_i or negedge rstn_i) begin : capture_regs
    if (!rstn_i) begin
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_post_cnt   <= '0;
      r_pre_n      <= '0;
      r_start_addr <= '0;
      r_mask       <= '0;
      r_value      <= '0;
      r_mode       <= M_LEVEL;
      r_match_d    <= 1'b0;
      r_triggered  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_match_d <= w_match;
      if (abort_i) begin
        r_triggered <= 1'b0;
        r_done      <= 1'b0;
      end else if (arm_i) begin
        r_wr_ptr    <= '0;
        r_cnt       <= '0;
        r_triggered <= 1'b0;
        r_done      <= 1'b0;
        // pretrig_i is ADDR_W wide, so it can never exceed DEPTH-1
        r_pre_n     <= pretrig_i;
        r_mask      <= trig_mask_i;
        r_value     <= trig_value_i;
        r_mode      <= trig_mode_i;
      end else begin
        if (w_wr_en)   r_wr_ptr <= r_wr_ptr + ONE;
        if (w_cnt_inc) r_cnt    <= r_cnt + ONE;
        if (w_trig_load) begin
          r_triggered  <= 1'b1;
          r_start_addr <= r_wr_ptr - r_pre_n;
          r_post_cnt   <= LAST - r_pre_n;
        end
        if (w_post_dec) r_post_cnt <= r_post_cnt - ONE;
        if (w_done_set) r_done     <= 1'b1;
      end
    end
  end

  // Sample buffer write port (no reset so it maps onto block RAM)
  always_ff @(posedge clk_i) begin : buf_write
    if (w_wr_en) r_mem[r_wr_ptr] <= data_i;
  end

  // Trigger-relative readout, one cycle latency
  assign w_rd_idx = r_start_addr + rd_addr_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin : buf_read
    if (!rstn_i) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) r_rd_data <= r_mem[w_rd_idx];
    end
  end

  assign rd_data_o    = r_rd_data;
  assign rd_valid_o   = r_rd_valid;
  assign state_o      = r_state;
  assign triggered_o  = r_triggered;
  assign done_o       = r_done;
  assign start_addr_o = r_start_addr;

endmodule

// File: tb/tb_la_capture_core.sv
// ---------------------------------------------------------------------------
// tb_la_capture_core
// Directed bench for la_capture_core with DATA_W=8, DEPTH=16. Inputs change
// 1 time unit after the rising edge; outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_la_capture_core;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] value;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] pretrig;
  logic              arm;
  logic              abort;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [2:0]        state;
  logic              triggered;
  logic              done;
  logic [ADDR_W-1:0] start_addr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] last_rd;

  la_capture_core #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .data_i      (data),
    .trig_mask_i (mask),
    .trig_value_i(value),
    .trig_mode_i (mode),
    .pretrig_i   (pretrig),
    .arm_i       (arm),
    .abort_i     (abort),
    .rd_en_i     (rd_en),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .state_o     (state),
    .triggered_o (triggered),
    .done_o      (done),
    .start_addr_o(start_addr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [7:0] mk,
                        input logic [7:0] v, input logic [3:0] p);
    mode = m; mask = mk; value = v; pretrig = p;
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [7:0] d,
                         output logic vld);
    rd_en = 1'b1; rd_addr = a;
    step();
    d = rd_data; vld = rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
    n_tests++;
    if (triggered !== 1'b0) begin n_fail++; $display("FAIL reset_trig got %b exp 0", triggered); end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_tests++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdvalid got %b exp 0", rd_valid); end
    n_tests++;
    if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rddata got %h exp 00", rd_data); end
    n_tests++;
    if (start_addr !== 4'd0) begin n_fail++; $display("FAIL reset_start got %0d exp 0", start_addr); end
    n_tests++;
  endtask

  task automatic test_immediate();
    logic [7:0] d;
    logic v;
    data = 8'h00;
    do_arm(2'd3, 8'h00, 8'h00, 4'd0);
    if (state !== 3'd2) begin n_fail++; $display("FAIL imm_wait got %0d exp 2", state); end
    n_tests++;
    for (int k = 0; k < 16; k++) begin
      data = 8'(10 + k);
      step();
      if (k == 14) begin
        if (done !== 1'b0) begin n_fail++; $display("FAIL imm_done_early got %b exp 0", done); end
        n_tests++;
      end
    end
    if (done !== 1'b1) begin n_fail++; $display("FAIL imm_done got %b exp 1", done); end
    n_tests++;
    if (state !== 3'd4) begin n_fail++; $display("FAIL imm_state got %0d exp 4", state); end
    n_tests++;
    if (start_addr !== 4'd0) begin n_fail++; $display("FAIL imm_start got %0d exp 0", start_addr); end
    n_tests++;
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i), d, v);
      if (v !== 1'b1 || d !== 8'(10 + i)) begin
        n_fail++; $display("FAIL imm_read[%0d] got %h/%b exp %h/1", i, d, v, 8'(10 + i));
      end
      n_tests++;
    end
    step();
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL imm_rdvalid_drop got %b exp 0", rd_valid); end
    n_tests++;
  endtask

  task automatic test_level();
    logic [7:0] d;
    logic v;
    logic [7:0] exp_buf [16];
    int c;
    data = 8'h00;
    do_arm(2'd0, 8'hFF, 8'hA5, 4'd4);
    c = 0;
    for (int k = 0; k < 24; k++) begin
      data = 8'(c); c++;
      step();
    end
    if (state !== 3'd2 || triggered !== 1'b0) begin
      n_fail++; $display("FAIL lvl_pre_trig got st%0d/%b exp st2/0", state, triggered);
    end
    n_tests++;
    data = 8'hA5; c++;
    step();
    if (triggered !== 1'b1 || state !== 3'd3) begin
      n_fail++; $display("FAIL lvl_trig got %b/st%0d exp 1/st3", triggered, state);
    end
    n_tests++;
    for (int k = 0; k < 11; k++) begin
      data = 8'(c); c++;
      step();
    end
    if (done !== 1'b1) begin n_fail++; $display("FAIL lvl_done got %b exp 1", done); end
    n_tests++;
    if (start_addr !== 4'd4) begin n_fail++; $display("FAIL lvl_start got %0d exp 4", start_addr); end
    n_tests++;
    for (int i = 0; i < 4; i++) exp_buf[i] = 8'(20 + i);
    exp_buf[4] = 8'hA5;
    for (int i = 5; i < 16; i++) exp_buf[i] = 8'(20 + i);
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i), d, v);
      if (v !== 1'b1 || d !== exp_buf[i]) begin
        n_fail++; $display("FAIL lvl_read[%0d] got %h/%b exp %h/1", i, d, v, exp_buf[i]);
      end
      n_tests++;
    end
  endtask

  task automatic test_edges();
    logic [7:0] d;
    logic v;
    // rising: bit0 held high through PRE/WAIT, then low, then high
    data = 8'h01;
    do_arm(2'd1, 8'h01, 8'h01, 4'd2);
    data = 8'h01; step();
    data = 8'h01; step();
    data = 8'h11; step();
    data = 8'h21; step();
    data = 8'h31; step();
    if (triggered !== 1'b0) begin n_fail++; $display("FAIL rise_held got %b exp 0", triggered); end
    n_tests++;
    data = 8'h40; step();
    if (triggered !== 1'b0) begin n_fail++; $display("FAIL rise_low got %b exp 0", triggered); end
    n_tests++;
    data = 8'h51; step();
    if (triggered !== 1'b1) begin n_fail++; $display("FAIL rise_edge got %b exp 1", triggered); end
    n_tests++;
    for (int k = 0; k < 13; k++) begin data = 8'h00; step(); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL rise_done got %b exp 1", done); end
    n_tests++;
    do_read(4'd0, d, v);
    if (d !== 8'h31) begin n_fail++; $display("FAIL rise_idx0 got %h exp 31", d); end
    n_tests++;
    do_read(4'd1, d, v);
    if (d !== 8'h40) begin n_fail++; $display("FAIL rise_idx1 got %h exp 40", d); end
    n_tests++;
    do_read(4'd2, d, v);
    if (d !== 8'h51) begin n_fail++; $display("FAIL rise_idx2 got %h exp 51", d); end
    n_tests++;

    // falling: same stimulus, trigger on the first low sample
    data = 8'h01;
    do_arm(2'd2, 8'h01, 8'h01, 4'd2);
    data = 8'h01; step();
    data = 8'h01; step();
    data = 8'h11; step();
    data = 8'h21; step();
    data = 8'h31; step();
    if (triggered !== 1'b0) begin n_fail++; $display("FAIL fall_held got %b exp 0", triggered); end
    n_tests++;
    data = 8'h40; step();
    if (triggered !== 1'b1) begin n_fail++; $display("FAIL fall_edge got %b exp 1", triggered); end
    n_tests++;
    for (int k = 0; k < 13; k++) begin data = 8'h00; step(); end
    if (done !== 1'b1) begin n_fail++; $display("FAIL fall_done got %b exp 1", done); end
    n_tests++;
    do_read(4'd1, d, v);
    if (d !== 8'h31) begin n_fail++; $display("FAIL fall_idx1 got %h exp 31", d); end
    n_tests++;
    do_read(4'd2, d, v);
    if (d !== 8'h40) begin n_fail++; $display("FAIL fall_idx2 got %h exp 40", d); end
    n_tests++;
  endtask

  task automatic test_clamp();
    logic [7:0] d;
    logic v;
    data = 8'h00;
    do_arm(2'd3, 8'h00, 8'h00, 4'd15);
    for (int k = 0; k < 15; k++) begin
      data = 8'(8'h80 + k);
      step();
    end
    if (state !== 3'd2 || done !== 1'b0) begin
      n_fail++; $display("FAIL clamp_wait got st%0d/%b exp st2/0", state, done);
    end
    n_tests++;
    data = 8'hC0; step();
    if (state !== 3'd4 || done !== 1'b1 || triggered !== 1'b1) begin
      n_fail++; $display("FAIL clamp_done got st%0d/%b/%b exp st4/1/1", state, done, triggered);
    end
    n_tests++;
    if (start_addr !== 4'd0) begin n_fail++; $display("FAIL clamp_start got %0d exp 0", start_addr); end
    n_tests++;
    do_read(4'd0, d, v);
    if (d !== 8'h80) begin n_fail++; $display("FAIL clamp_idx0 got %h exp 80", d); end
    n_tests++;
    do_read(4'd14, d, v);
    if (d !== 8'h8E) begin n_fail++; $display("FAIL clamp_idx14 got %h exp 8e", d); end
    n_tests++;
    do_read(4'd15, d, v);
    if (d !== 8'hC0) begin n_fail++; $display("FAIL clamp_idx15 got %h exp c0", d); end
    n_tests++;
    last_rd = 8'hC0;
  endtask

  task automatic test_abort_arm();
    logic [7:0] d;
    logic v;
    data = 8'h00;
    do_arm(2'd0, 8'hFF, 8'hFF, 4'd0);
    step(); step();
    if (state !== 3'd2) begin n_fail++; $display("FAIL ab_wait got %0d exp 2", state); end
    n_tests++;
    abort = 1'b1; arm = 1'b1;
    step();
    abort = 1'b0; arm = 1'b0;
    if (state !== 3'd0 || done !== 1'b0 || triggered !== 1'b0) begin
      n_fail++; $display("FAIL ab_idle got st%0d/%b/%b exp st0/0/0", state, done, triggered);
    end
    n_tests++;
    do_read(4'd3, d, v);
    if (v !== 1'b0) begin n_fail++; $display("FAIL ab_rdvalid got %b exp 0", v); end
    n_tests++;
    if (d !== last_rd) begin n_fail++; $display("FAIL ab_rdhold got %h exp %h", d, last_rd); end
    n_tests++;
    do_arm(2'd3, 8'h00, 8'h00, 4'd0);
    for (int k = 0; k < 16; k++) begin
      data = 8'(8'h60 + k);
      step();
    end
    if (done !== 1'b1) begin n_fail++; $display("FAIL ab_rearm_done got %b exp 1", done); end
    n_tests++;
    do_read(4'd3, d, v);
    if (v !== 1'b1 || d !== 8'h63) begin
      n_fail++; $display("FAIL ab_rearm_read got %h/%b exp 63/1", d, v);
    end
    n_tests++;
  endtask

  task automatic test_reset_mid_post();
    data = 8'h00;
    do_arm(2'd3, 8'h00, 8'h00, 4'd0);
    step(); step(); step();
    if (state !== 3'd3 || triggered !== 1'b1) begin
      n_fail++; $display("FAIL rst_post got st%0d/%b exp st3/1", state, triggered);
    end
    n_tests++;
    #2 rstn = 1'b0;
    #1;
    if (state !== 3'd0 || triggered !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_async got st%0d/%b/%b exp st0/0/0", state, triggered, done);
    end
    n_tests++;
    if (start_addr !== 4'd0 || rd_data !== 8'h00) begin
      n_fail++; $display("FAIL rst_async_regs got %0d/%h exp 0/00", start_addr, rd_data);
    end
    n_tests++;
    #2 rstn = 1'b1;
    step();
    if (state !== 3'd0) begin n_fail++; $display("FAIL rst_release got %0d exp 0", state); end
    n_tests++;
  endtask

  initial begin
    rstn = 1'b0; data = '0; mask = '0; value = '0; mode = '0; pretrig = '0;
    arm = 1'b0; abort = 1'b0; rd_en = 1'b0; rd_addr = '0; last_rd = '0;
    #23 rstn = 1'b1;
    step();
    test_reset();
    test_immediate();
    test_level();
    test_edges();
    test_clamp();
    test_abort_arm();
    test_reset_mid_post();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
